// File: rtl/cvxif_mac8_copro.sv
// ---------------------------------------------------------------------------
// cvxif_mac8_copro
//
// CV-X-IF style coprocessor for int8 inference kernels (XLEN = 32).
// Claims custom-0 instructions with funct7 == 0 and funct3 in 000..011:
//   000 DOT4 : acc += sum of four signed int8 lane products, returns new acc
//   001 CLR  : returns old acc, acc = 0
//   010 SHR  : returns sext(sat8(acc >>> rs2[4:0])), acc unchanged
//   011 LDA  : returns old acc, acc = rs1
// DOT4 is computed one lane product per cycle (4 MAC cycles). All other
// ops complete in the accept cycle. One writeback is produced per accepted
// instruction and is held until the core takes it.
//
// Build option:
//   CVXIF_MAC_SAT_EN  defined   -> DOT4 accumulate saturates to int32 range
//                     undefined -> DOT4 accumulate wraps modulo 2^32
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   issue_valid_i/ready_o   offload request handshake (ready only when idle)
//   issue_instr_i           instruction word (decoded combinationally)
//   issue_id_i              tag echoed back on result_id_o
//   issue_rs1_i/rs2_i       register operands
//   issue_accept_o          1 when issue_instr_i is an instruction we claim
//   result_valid_o/ready_i  writeback handshake
//   result_id_o, result_rd_o, result_data_o, result_we_o  writeback fields
// ---------------------------------------------------------------------------
module cvxif_mac8_copro #(
    parameter int          XLEN     = 32,
    parameter int          ID_WIDTH = 3,
    parameter logic [6:0]  OPCODE   = 7'b0001011
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic [XLEN-1:0]     issue_rs2_i,
    output logic                issue_accept_o,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [4:0]          result_rd_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic                result_we_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [2:0] F3_DOT4 = 3'b000;
    localparam logic [2:0] F3_CLR  = 3'b001;
    localparam logic [2:0] F3_SHR  = 3'b010;
    localparam logic [2:0] F3_LDA  = 3'b011;

    logic [1:0]          state_reg;
    logic [1:0]          lane_reg;
    logic signed [17:0]  partial_reg;
    logic [31:0]         op_a_reg;
    logic [31:0]         op_b_reg;
    logic [ID_WIDTH-1:0] id_reg;
    logic [4:0]          rd_reg;
    logic [31:0]         data_reg;
    logic signed [31:0]  acc_reg;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       decode_ok;
    logic       issue_fire;
    logic       unused_instr_bits;

    assign opcode    = issue_instr_i[6:0];
    assign funct3    = issue_instr_i[14:12];
    assign funct7    = issue_instr_i[31:25];
    // funct3 values 000..011 are exactly those with bit 2 clear.
    assign decode_ok = (opcode == OPCODE) && (funct7 == 7'd0) && !funct3[2];
    // Register specifier fields are irrelevant: operands arrive by value.
    assign unused_instr_bits = ^issue_instr_i[24:15];

    assign issue_ready_o  = (state_reg == IDLE);
    assign issue_accept_o = decode_ok;
    assign issue_fire     = issue_valid_i && issue_ready_o && decode_ok;

    // ------------------------------------------------------------------
    // Lane products: all four are formed, the lane counter picks one.
    // ------------------------------------------------------------------
    logic signed [15:0] lane_prod [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_prod[gi] = $signed(op_a_reg[8*gi +: 8]) * $signed(op_b_reg[8*gi +: 8]);
        end
    endgenerate

    logic signed [15:0] cur_prod;
    logic signed [17:0] partial_sum;
    logic signed [31:0] lane_ext;
    logic signed [31:0] acc_new;

    assign cur_prod    = lane_prod[lane_reg];
    assign partial_sum = partial_reg + {{2{cur_prod[15]}}, cur_prod};
    assign lane_ext    = {{14{partial_sum[17]}}, partial_sum};

`ifdef CVXIF_MAC_SAT_EN
    // One extra bit exposes signed overflow: the top two bits disagree.
    logic [32:0] acc_sum_wide;
    assign acc_sum_wide = {acc_reg[31], acc_reg} + {lane_ext[31], lane_ext};

    always_comb begin
        acc_new = acc_sum_wide[31:0];
        if (acc_sum_wide[32] != acc_sum_wide[31]) begin
            acc_new = acc_sum_wide[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end
    end
`else
    assign acc_new = acc_reg + lane_ext;
`endif

    // ------------------------------------------------------------------
    // Requantising readout: arithmetic shift then clamp to int8.
    // ------------------------------------------------------------------
    logic signed [31:0] shr_shifted;
    logic [31:0]        shr_data;

    assign shr_shifted = acc_reg >>> issue_rs2_i[4:0];

    always_comb begin
        shr_data = shr_shifted;
        if (shr_shifted > 32'sd127) begin
            shr_data = 32'h0000_007F;
        end else if (shr_shifted < -32'sd128) begin
            shr_data = 32'hFFFF_FF80;
        end
    end

    // ------------------------------------------------------------------
    // Control and datapath state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            lane_reg    <= 2'd0;
            partial_reg <= '0;
            op_a_reg    <= '0;
            op_b_reg    <= '0;
            id_reg      <= '0;
            rd_reg      <= '0;
            data_reg    <= '0;
            acc_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (issue_fire) begin
                        id_reg <= issue_id_i;
                        rd_reg <= issue_instr_i[11:7];
                        case (funct3)
                            F3_DOT4: begin
                                op_a_reg    <= issue_rs1_i;
                                op_b_reg    <= issue_rs2_i;
                                lane_reg    <= 2'd0;
                                partial_reg <= '0;
                                state_reg   <= MAC;
                            end
                            F3_CLR: begin
                                data_reg  <= acc_reg;
                                acc_reg   <= '0;
                                state_reg <= RESP;
                            end
                            F3_SHR: begin
                                data_reg  <= shr_data;
                                state_reg <= RESP;
                            end
                            F3_LDA: begin
                                data_reg  <= acc_reg;
                                acc_reg   <= issue_rs1_i;
                                state_reg <= RESP;
                            end
                            default: state_reg <= IDLE;
                        endcase
                    end
                end
                MAC: begin
                    partial_reg <= partial_sum;
                    lane_reg    <= lane_reg + 2'd1;
                    if (lane_reg == 2'd3) begin
                        acc_reg   <= acc_new;
                        data_reg  <= acc_new;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (result_ready_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Result fields read as zero whenever no result is being offered.
    assign result_valid_o = (state_reg == RESP);
    assign result_we_o    = result_valid_o;
    assign result_id_o    = result_valid_o ? id_reg   : '0;
    assign result_rd_o    = result_valid_o ? rd_reg   : '0;
    assign result_data_o  = result_valid_o ? data_reg : '0;

endmodule
